// File: rtl/nest_block_checker.sv
// Streaming keyword-nesting checker: splits an ASCII byte stream into words and
// verifies begin/end and fork/join pairs nest properly within a bounded type stack.
module nest_block_checker #(
  parameter int DEPTH     = 16,
  parameter bit EXT_DELIM = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in,
  output logic                       result,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int DW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    KW_NONE  = 3'd0,
    KW_BEGIN = 3'd1,
    KW_END   = 3'd2,
    KW_FORK  = 3'd3,
    KW_JOIN  = 3'd4
  } kw_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_MISMATCH  = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_e;

  // Stack entry types: 0 = begin/end, 1 = fork/join.
  localparam logic TYPE_BE = 1'b0;
  localparam logic TYPE_FJ = 1'b1;

  function automatic logic [7:0] kw_char(input kw_e kw, input logic [2:0] i);
    logic [7:0] c;
    c = 8'h00;
    case (kw)
      KW_BEGIN:
        case (i)
          3'd0: c = "b";
          3'd1: c = "e";
          3'd2: c = "g";
          3'd3: c = "i";
          3'd4: c = "n";
          default: c = 8'h00;
        endcase
      KW_END:
        case (i)
          3'd0: c = "e";
          3'd1: c = "n";
          3'd2: c = "d";
          default: c = 8'h00;
        endcase
      KW_FORK:
        case (i)
          3'd0: c = "f";
          3'd1: c = "o";
          3'd2: c = "r";
          3'd3: c = "k";
          default: c = 8'h00;
        endcase
      KW_JOIN:
        case (i)
          3'd0: c = "j";
          3'd1: c = "o";
          3'd2: c = "i";
          3'd3: c = "n";
          default: c = 8'h00;
        endcase
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Committed state
  logic [DEPTH-1:0] stack;
  logic [DW-1:0]    depth_q;
  logic             err_q;
  err_e             err_code_q;

  // Word tracker: char index saturating at 7 plus one live-match flag per keyword
  logic [2:0] idx;
  logic       m_begin, m_end, m_fork, m_join;

  logic       is_delim;
  logic [7:0] folded;
  kw_e        pend;
  logic       top;

  always_comb begin
    is_delim = (in == 8'h20);
    if (EXT_DELIM)
      is_delim = is_delim || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
  end

  // Only A-Z fold; digits and punctuation must match exactly.
  assign folded = ((in >= 8'h41) && (in <= 8'h5A)) ? (in | 8'h20) : in;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    pend = KW_NONE;
    if (m_begin && idx == 3'd5)      pend = KW_BEGIN;
    else if (m_end  && idx == 3'd3)  pend = KW_END;
    else if (m_fork && idx == 3'd4)  pend = KW_FORK;
    else if (m_join && idx == 3'd4)  pend = KW_JOIN;
  end

  // Top of stack is entry[depth-1]; 0 when the stack is empty.
  always_comb begin
    top = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(depth_q) == i + 1) top = stack[i];
  end

  // Commit decisions for the word being closed by a delimiter this cycle
  logic commit;
  logic push_en, pop_en, err_set;
  logic push_type;
  err_e err_next;

  assign commit = in_valid && is_delim && !err_q;

  always_comb begin
    push_en   = 1'b0;
    pop_en    = 1'b0;
    err_set   = 1'b0;
    err_next  = ERR_NONE;
    push_type = TYPE_BE;
    if (commit) begin
      case (pend)
        KW_BEGIN, KW_FORK: begin
          push_type = (pend == KW_FORK) ? TYPE_FJ : TYPE_BE;
          if (depth_q == DW'(DEPTH)) begin
            err_set  = 1'b1;
            err_next = ERR_OVERFLOW;
          end else begin
            push_en = 1'b1;
          end
        end
        KW_END, KW_JOIN: begin
          if (depth_q == '0) begin
            err_set  = 1'b1;
            err_next = ERR_UNDERFLOW;
          end else if (top != ((pend == KW_JOIN) ? TYPE_FJ : TYPE_BE)) begin
            err_set  = 1'b1;
            err_next = ERR_MISMATCH;
          end else begin
            pop_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stack is only 1 bit per entry, so it is reset with everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack      <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      idx        <= 3'd0;
      m_begin    <= 1'b1;
      m_end      <= 1'b1;
      m_fork     <= 1'b1;
      m_join     <= 1'b1;
    end else if (in_valid) begin
      // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
      if (is_delim) begin
        idx     <= 3'd0;
        m_begin <= 1'b1;
        m_end   <= 1'b1;
        m_fork  <= 1'b1;
        m_join  <= 1'b1;
      end else begin
        idx     <= (idx == 3'd7) ? 3'd7 : idx + 3'd1;
        m_begin <= m_begin && (idx < 3'd5) && (folded == kw_char(KW_BEGIN, idx));
        m_end   <= m_end   && (idx < 3'd3) && (folded == kw_char(KW_END,   idx));
        m_fork  <= m_fork  && (idx < 3'd4) && (folded == kw_char(KW_FORK,  idx));
        m_join  <= m_join  && (idx < 3'd4) && (folded == kw_char(KW_JOIN,  idx));
      end

      if (push_en) begin
        for (int i = 0; i < DEPTH; i++)
          if (int'(depth_q) == i) stack[i] <= push_type;
        depth_q <= depth_q + DW'(1);
      end else if (pop_en) begin
        depth_q <= depth_q - DW'(1);
      end

      if (err_set) begin
        err_q      <= 1'b1;
        err_code_q <= err_next;
      end
    end
  end

  // Balanced-if-the-stream-ended-now, including the partial word.
  always_comb begin
    result = 1'b0;
    if (!err_q) begin
      case (pend)
        KW_BEGIN, KW_FORK: result = 1'b0;
        KW_END:  result = (depth_q == DW'(1)) && (top == TYPE_BE);
        KW_JOIN: result = (depth_q == DW'(1)) && (top == TYPE_FJ);
        default: result = (depth_q == '0);
      endcase
    end
  end

  assign depth    = depth_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_nest_block_checker.sv
// Self-checking bench for nest_block_checker: three configurations share one
// input stream; expected values are queued per byte and compared after the edge.
module tb_nest_block_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;

  // sel 0: DEPTH=16, EXT_DELIM=0
  logic       res_a, err_a;
  logic [4:0] dep_a;
  logic [1:0] code_a;
  // sel 1: DEPTH=2, EXT_DELIM=0
  logic       res_b, err_b;
  logic [1:0] dep_b;
  logic [1:0] code_b;
  // sel 2: DEPTH=16, EXT_DELIM=1
  logic       res_c, err_c;
  logic [4:0] dep_c;
  logic [1:0] code_c;

  nest_block_checker #(.DEPTH(16), .EXT_DELIM(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(res_a), .depth(dep_a), .err(err_a), .err_code(code_a));

  nest_block_checker #(.DEPTH(2), .EXT_DELIM(1'b0)) dut_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(res_b), .depth(dep_b), .err(err_b), .err_code(code_b));

  nest_block_checker #(.DEPTH(16), .EXT_DELIM(1'b1)) dut_x (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(res_c), .depth(dep_c), .err(err_c), .err_code(code_c));

  always #5 clk = ~clk;

  typedef struct {
    int    sel;
    bit    res;
    int    dep;
    bit    err;
    int    code;
    string name;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_state(input int sel, input bit r, input int d, input bit e,
                              input int c, input string name);
    exp_t x;
    x.sel = sel; x.res = r; x.dep = d; x.err = e; x.code = c; x.name = name;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic ar, ae;
    int   ad, ac;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        0:       begin ar = res_a; ad = int'(dep_a); ae = err_a; ac = int'(code_a); end
        1:       begin ar = res_b; ad = int'(dep_b); ae = err_b; ac = int'(code_b); end
        default: begin ar = res_c; ad = int'(dep_c); ae = err_c; ac = int'(code_c); end
      endcase
      total++;
      if (ar !== x.res) $display("FAIL %s[%0d] result: got %b want %b", x.name, x.sel, ar, x.res);
      else passed++;
      total++;
      if (ad !== x.dep) $display("FAIL %s[%0d] depth: got %0d want %0d", x.name, x.sel, ad, x.dep);
      else passed++;
      total++;
      if (ae !== x.err) $display("FAIL %s[%0d] err: got %b want %b", x.name, x.sel, ae, x.err);
      else passed++;
      total++;
      if (ac !== x.code) $display("FAIL %s[%0d] err_code: got %0d want %0d", x.name, x.sel, ac, x.code);
      else passed++;
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input bit v);
    @(negedge clk);
    in = c;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
  endtask

  // Sends s; the expectation is queued with the last byte and checked after its edge.
  // With gap=1 an invalid space precedes every byte and must be ignored.
  task automatic sendx(input string s, input bit gap, input int sel, input bit r,
                       input int d, input bit e, input int c, input string name);
    logic [7:0] ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (gap) send_byte(8'h20, 1'b0);
      if (i == s.len() - 1) expect_state(sel, r, d, e, c, name);
      send_byte(ch, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    for (int s = 0; s < 3; s++) expect_state(s, 1'b1, 0, 1'b0, 0, "reset");
    drain();
    reset = 1'b0;
  endtask

  task automatic test_nesting();
    do_reset();
    sendx("BeGiN", 0, 0, 1'b0, 0, 1'b0, 0, "pend_begin");
    sendx(" ",     0, 0, 1'b0, 1, 1'b0, 0, "push_begin");
    sendx("fork ", 0, 0, 1'b0, 2, 1'b0, 0, "push_fork");
    sendx("JOIN",  0, 0, 1'b0, 2, 1'b0, 0, "pend_join_d2");
    sendx(" ",     0, 0, 1'b0, 1, 1'b0, 0, "pop_fork");
    sendx("End",   0, 0, 1'b1, 1, 1'b0, 0, "pend_end_match");
    sendx(" ",     0, 0, 1'b1, 0, 1'b0, 0, "balanced");
    sendx("begin1 be_gin ", 0, 0, 1'b1, 0, 1'b0, 0, "non_keywords");
    expect_state(2, 1'b1, 0, 1'b0, 0, "balanced_ext");
    drain();
  endtask

  task automatic test_mismatch();
    do_reset();
    sendx("begin join", 0, 0, 1'b0, 1, 1'b0, 0, "pend_join_mismatch");
    sendx(" ",          0, 0, 1'b0, 1, 1'b1, 2, "mismatch");
    sendx("end ",       0, 0, 1'b0, 1, 1'b1, 2, "mismatch_frozen");
  endtask

  task automatic test_underflow();
    do_reset();
    sendx("end",        0, 0, 1'b0, 0, 1'b0, 0, "pend_end_d0");
    sendx(" ",          0, 0, 1'b0, 0, 1'b1, 1, "underflow");
    sendx("begin end ", 0, 0, 1'b0, 0, 1'b1, 1, "underflow_sticky");
  endtask

  task automatic test_overflow();
    do_reset();
    sendx("begin fork ", 0, 1, 1'b0, 2, 1'b0, 0, "d2_full");
    sendx("begin ",      0, 1, 1'b0, 2, 1'b1, 3, "overflow");
    expect_state(0, 1'b0, 3, 1'b0, 0, "deep_ok");
    drain();
    sendx("join end ",   0, 1, 1'b0, 2, 1'b1, 3, "overflow_sticky");
  endtask

  task automatic test_gaps();
    do_reset();
    sendx("beginx",  1, 0, 1'b1, 0, 1'b0, 0, "long_word");
    sendx("   endd ", 1, 0, 1'b1, 0, 1'b0, 0, "endd_ignored");
    sendx("begin",   1, 0, 1'b0, 0, 1'b0, 0, "gap_pend_begin");
    sendx(" ",       1, 0, 1'b0, 1, 1'b0, 0, "gap_push");
    sendx("end",     1, 0, 1'b1, 1, 1'b0, 0, "gap_pend_end");
    sendx(" ",       1, 0, 1'b1, 0, 1'b0, 0, "gap_pop");
  endtask

  task automatic test_ext_delim();
    do_reset();
    sendx("begin\t", 0, 2, 1'b0, 1, 1'b0, 0, "ext_tab_push");
    expect_state(0, 1'b1, 0, 1'b0, 0, "noext_tab_word");
    drain();
    sendx("end",     0, 2, 1'b1, 1, 1'b0, 0, "ext_pend_end");
    sendx("\n",      0, 2, 1'b1, 0, 1'b0, 0, "ext_lf_pop");
    expect_state(0, 1'b1, 0, 1'b0, 0, "noext_one_word");
    drain();
  endtask

  task automatic test_reset_midword();
    do_reset();
    sendx("fork begi", 0, 2, 1'b0, 1, 1'b0, 0, "pre_reset");
    reset = 1'b1;
    #1;
    expect_state(2, 1'b1, 0, 1'b0, 0, "async_reset");
    drain();
    #2;
    reset = 1'b0;
    sendx("n ", 0, 2, 1'b1, 0, 1'b0, 0, "word_discarded");
  endtask

  initial begin
    test_reset();
    test_nesting();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_gaps();
    test_ext_delim();
    test_reset_midword();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
